// File: rtl/cam_pkg.sv
// Shared camera-path definitions: frame geometry defaults, bus widths,
// background-controller state encoding and the write-port payload.
package cam_pkg;

    localparam int unsigned FRAME_WIDTH_DEF  = 320;
    localparam int unsigned FRAME_HEIGHT_DEF = 240;
    localparam int unsigned ADDR_W           = 17;
    localparam int unsigned PIX_W            = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_BG_LOAD = 2'd2
    } bg_state_e;

    // One frame-buffer write beat
    typedef struct packed {
        logic              wren;
        logic [ADDR_W-1:0] addr;
        logic [PIX_W-1:0]  data;
    } wr_beat_t;

endpackage

// File: rtl/bg_frame_ctrl_if.sv
// Camera pixel stream in, live/background buffer write ports and status out.
// master: camera/host side (drives stream and capture request)
// slave : bg_frame_ctrl (drives buffer write ports and status)
interface bg_frame_ctrl_if;
    import cam_pkg::*;

    logic              vsync;
    logic              pix_valid;
    logic [PIX_W-1:0]  pix_data;
    logic              bg_capture_req;

    logic              fg_wren;
    logic [ADDR_W-1:0] fg_wraddress;
    logic [PIX_W-1:0]  fg_wrdata;

    logic              bg_wren;
    logic [ADDR_W-1:0] bg_wraddress;
    logic [PIX_W-1:0]  bg_wrdata;

    logic              bg_valid;
    logic              busy;
    logic              short_frame;

    modport master (
        output vsync, pix_valid, pix_data, bg_capture_req,
        input  fg_wren, fg_wraddress, fg_wrdata,
        input  bg_wren, bg_wraddress, bg_wrdata,
        input  bg_valid, busy, short_frame
    );

    modport slave (
        input  vsync, pix_valid, pix_data, bg_capture_req,
        output fg_wren, fg_wraddress, fg_wrdata,
        output bg_wren, bg_wraddress, bg_wrdata,
        output bg_valid, busy, short_frame
    );

endinterface

// File: rtl/vsync_edge_det.sv
// Rising-edge detector for vsync.
// Ports: clk, rst (async, active-high), i_vsync, o_rise_c (combinational pulse).
// The history register resets high so a vsync already high at reset release
// is not mistaken for a frame start.
module vsync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic i_vsync,
    output logic o_rise_c
);

    logic r_vsync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_vsync_q <= 1'b1;
        else     r_vsync_q <= i_vsync;
    end

    assign o_rise_c = i_vsync & ~r_vsync_q;

endmodule

// File: rtl/bg_frame_ctrl.sv
// Writes every camera frame into the live buffer and, on request, snapshots
// the next complete frame into the background buffer.
// Ports: clk_25MHz, rst (async, active-high), bus (bg_frame_ctrl_if.slave):
//   stream in (vsync, pix_valid, pix_data, bg_capture_req),
//   fg_*/bg_* buffer write ports, bg_valid, busy, short_frame.
module bg_frame_ctrl
    import cam_pkg::*;
#(
    parameter int unsigned FRAME_WIDTH  = FRAME_WIDTH_DEF,
    parameter int unsigned FRAME_HEIGHT = FRAME_HEIGHT_DEF
) (
    input  logic            clk_25MHz,
    input  logic            rst,
    bg_frame_ctrl_if.slave  bus
);

    localparam int unsigned       FRAME_PIXELS = FRAME_WIDTH * FRAME_HEIGHT;
    localparam logic [ADDR_W:0]   PIX_LIMIT    = (ADDR_W+1)'(FRAME_PIXELS);
    localparam logic [ADDR_W-1:0] LAST_ADDR    = ADDR_W'(FRAME_PIXELS - 1);

    bg_state_e         r_state, w_state_nxt;
    logic              w_rise;
    logic [ADDR_W-1:0] r_addr, w_addr;
    logic              w_accept, w_bg_wr, w_abort, w_load_start;
    wr_beat_t          r_fg, r_bg;
    logic              r_bg_valid, r_busy, r_short;

    vsync_edge_det u_vsync_edge (
        .clk      (clk_25MHz),
        .rst      (rst),
        .i_vsync  (bus.vsync),
        .o_rise_c (w_rise)
    );

    // A pixel arriving with the vsync rise belongs to the new frame (address 0)
    assign w_addr   = w_rise ? '0 : r_addr;
    assign w_accept = bus.pix_valid && ({1'b0, w_addr} < PIX_LIMIT);

    // State register
    always_ff @(posedge clk_25MHz or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state and capture decisions
    always_comb begin
        w_state_nxt  = r_state;
        w_bg_wr      = 1'b0;
        w_abort      = 1'b0;
        w_load_start = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.bg_capture_req) w_state_nxt = ST_ARMED;
            end
            ST_ARMED: begin
                if (w_rise) begin
                    w_state_nxt  = ST_BG_LOAD;
                    w_load_start = 1'b1;
                    w_bg_wr      = w_accept;
                end
            end
            ST_BG_LOAD: begin
                // Early vsync: the frame is short, re-arm for the one after
                if (w_rise) begin
                    w_state_nxt = ST_ARMED;
                    w_abort     = 1'b1;
                end else begin
                    w_bg_wr = w_accept;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_bg_wr && (w_addr == LAST_ADDR)) w_state_nxt = ST_IDLE;
    end

    // Address counter, write ports and status flags
    always_ff @(posedge clk_25MHz or posedge rst) begin
        if (rst) begin
            r_addr     <= '0;
            r_fg       <= '0;
            r_bg       <= '0;
            r_bg_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_short    <= 1'b0;
        end else begin
            // Saturates at FRAME_PIXELS; extra beats are dropped until vsync
            r_addr  <= w_accept ? w_addr + 1'b1 : w_addr;
            r_fg.wren <= w_accept;
            if (w_accept) begin
                r_fg.addr <= w_addr;
                r_fg.data <= bus.pix_data;
            end
            r_bg.wren <= w_bg_wr;
            if (w_bg_wr) begin
                r_bg.addr <= w_addr;
                r_bg.data <= bus.pix_data;
            end
            r_short <= w_abort;
            r_busy  <= (w_state_nxt != ST_IDLE);
            // Valid follows the last background write by one cycle
            if (w_load_start || w_abort)
                r_bg_valid <= 1'b0;
            else if (r_bg.wren && (r_bg.addr == LAST_ADDR))
                r_bg_valid <= 1'b1;
        end
    end

    assign bus.fg_wren      = r_fg.wren;
    assign bus.fg_wraddress = r_fg.addr;
    assign bus.fg_wrdata    = r_fg.data;
    assign bus.bg_wren      = r_bg.wren;
    assign bus.bg_wraddress = r_bg.addr;
    assign bus.bg_wrdata    = r_bg.data;
    assign bus.bg_valid     = r_bg_valid;
    assign bus.busy         = r_busy;
    assign bus.short_frame  = r_short;

endmodule

// File: doc/bg_frame_ctrl.md
BG_FRAME_CTRL -- requirements
Module: bg_frame_ctrl

Interface
- REQ-001 SHALL have parameter FRAME_WIDTH, default 320, active pixels per line.
- REQ-002 SHALL have parameter FRAME_HEIGHT, default 240, lines per frame; FRAME_PIXELS = FRAME_WIDTH*FRAME_HEIGHT.
- REQ-003 SHALL have port clk_25MHz, input, 1, the single clock; all logic on its rising edge.
- REQ-004 SHALL have port rst, input, 1; reset is asynchronous and active-high.
- REQ-005 SHALL have port vsync, input, 1, frame sync; a rising edge marks frame start.
- REQ-006 SHALL have port pix_valid, input, 1, qualifies pix_data for one cycle.
- REQ-007 SHALL have port pix_data, input, 16, RGB565 camera pixel.
- REQ-008 SHALL have port bg_capture_req, input, 1, single-cycle request to snapshot the next full frame as background.
- REQ-009 SHALL have ports fg_wren (output, 1), fg_wraddress (output, 17) and fg_wrdata (output, 16), the live-frame buffer write port.
- REQ-010 SHALL have ports bg_wren (output, 1), bg_wraddress (output, 17) and bg_wrdata (output, 16), the background buffer write port.
- REQ-011 SHALL have output bg_valid, 1, set when the background buffer holds a complete frame.
- REQ-012 SHALL have output busy, 1, high in ARMED or BG_LOAD.
- REQ-013 SHALL have output short_frame, 1, a one-cycle pulse when a background load is aborted.

Function
- REQ-014 SHALL detect a vsync rise as vsync & ~vsync_q; vsync_q resets to 1 so no false edge occurs after reset.
- REQ-015 SHALL clear the 17-bit pixel address counter to 0 on every vsync rise, independent of FSM state.
- REQ-016 SHALL, on pix_valid with address < FRAME_PIXELS, register fg_wren=1, fg_wraddress=addr and fg_wrdata=pix_data (1-cycle latency), then increment addr.
- REQ-017 SHALL drop pix_valid beats once addr reaches FRAME_PIXELS (no write, no wrap) until the next vsync rise.
- REQ-018 SHALL implement FSM states IDLE, ARMED and BG_LOAD.
- REQ-019 IDLE: bg_capture_req -> ARMED.
- REQ-020 ARMED: vsync rise -> BG_LOAD, and the frame beginning at that edge is captured.
- REQ-021 BG_LOAD: each accepted pixel (REQ-016) SHALL also drive bg_wren/bg_wraddress/bg_wrdata, with the same timing and values as the fg port.
- REQ-022 BG_LOAD: the write of address FRAME_PIXELS-1 -> IDLE, and bg_valid is set on the cycle after that write.
- REQ-023 BG_LOAD: a vsync rise before FRAME_PIXELS pixels are accepted SHALL pulse short_frame, clear bg_valid, and go to ARMED; the new frame starting at that edge is not captured.
- REQ-024 SHALL ignore bg_capture_req in ARMED or BG_LOAD (not queued).
- REQ-025 A vsync rise and pix_valid in the same cycle: the pixel SHALL be written at address 0 and addr becomes 1.
- REQ-026 bg_capture_req and a vsync rise in the same cycle in IDLE -> ARMED only; capture starts at the following vsync rise.
- REQ-027 On entering BG_LOAD, bg_valid SHALL be cleared, since the old background is being overwritten.

Reset
- REQ-028 rst SHALL asynchronously force IDLE, addr=0, vsync_q=1, and all outputs 0 (wren, wraddress, wrdata, bg_valid, busy, short_frame).
- REQ-029 rst asserted mid-BG_LOAD SHALL abandon the load, leaving bg_valid=0; buffer contents are undefined.

Structure
- REQ-030 SHALL take FRAME_WIDTH/FRAME_HEIGHT defaults, ADDR_W=17 and the FSM state encoding from shared package cam_pkg.
- REQ-031 SHALL instantiate one sub-module, vsync_edge_det (registered rise detector, reset value 1).

Verification
- REQ-032 Reset, then two 76800-pixel frames with no request -> fg written at 0..76799 each frame, bg_wren never 1, bg_valid=0.
- REQ-033 bg_capture_req mid-frame -> busy=1, no bg write until the next vsync rise; that frame writes bg 0..76799; bg_valid=1 one cycle after address 76799.
- REQ-034 Armed, then vsync rise after only 1000 pixels of a BG_LOAD frame -> short_frame pulses once, bg_valid=0, the next full frame completes the capture.
- REQ-035 80000 pix_valid beats in one frame -> the last write is at 76799; beats 76800..79999 are dropped.
- REQ-036 rst asserted at pixel 500 of BG_LOAD -> all outputs 0 immediately, state IDLE, no spurious edge after release with vsync high.
- REQ-037 vsync rise coincident with pix_valid data 16'hF800 -> fg_wraddress=0 and fg_wrdata=16'hF800 on the next cycle.
